// File: rtl/booth_product_accumulator.sv
// Sums a programmed number of signed 8-bit Booth products into an ACC_W accumulator.
// Optional build macro BOOTH_ACC_SAT_EN: saturate instead of wrap on signed overflow.
module booth_product_accumulator #(
  parameter int ACC_W = 16,
  parameter int CNT_W = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic [CNT_W-1:0]        len,
  input  logic                    prod_valid,
  output logic                    prod_ready,
  input  logic signed [7:0]       prod_data,
  output logic                    res_valid,
  input  logic                    res_ready,
  output logic signed [ACC_W-1:0] res_data,
  output logic                    ovf,
  output logic                    busy
);

  typedef enum logic [1:0] {IDLE, ACC, DONE} state_t;

  localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

  state_t                  state;
  logic [CNT_W-1:0]        len_q;
  logic [CNT_W-1:0]        cnt;
  logic [CNT_W-1:0]        cnt_inc;
  logic signed [ACC_W-1:0] acc;
  logic signed [ACC_W-1:0] prod_ext;
  logic signed [ACC_W-1:0] sum_raw;
  logic signed [ACC_W-1:0] acc_next;
  logic                    add_ovf;

  function automatic logic signed [ACC_W-1:0] sign_extend(input logic signed [7:0] p);
    return ACC_W'(p);
  endfunction

  // Same-sign addends whose sum flips sign.
  function automatic logic signed_overflow(input logic signed [ACC_W-1:0] a,
                                           input logic signed [ACC_W-1:0] b,
                                           input logic signed [ACC_W-1:0] s);
    return (a[ACC_W-1] == b[ACC_W-1]) && (s[ACC_W-1] != a[ACC_W-1]);
  endfunction

  function automatic logic signed [ACC_W-1:0] saturate(input logic signed [ACC_W-1:0] a,
                                                       input logic signed [ACC_W-1:0] s,
                                                       input logic                    o);
`ifdef BOOTH_ACC_SAT_EN
    if (o) return a[ACC_W-1] ? ACC_MIN : ACC_MAX;
    return s;
`else
    // The wrap build discards the clamp; the wrapped sum is the result.
    logic unused;
    unused = ^{a, o};
    return s;
`endif
  endfunction

  always_comb begin
    prod_ext = sign_extend(prod_data);
    sum_raw  = acc + prod_ext;
    add_ovf  = signed_overflow(acc, prod_ext, sum_raw);
    acc_next = saturate(acc, sum_raw, add_ovf);
    cnt_inc  = cnt + CNT_W'(1);
  end

  assign res_data = acc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      len_q      <= '0;
      cnt        <= '0;
      acc        <= '0;
      ovf        <= 1'b0;
      prod_ready <= 1'b0;
      res_valid  <= 1'b0;
      busy       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            len_q <= len;
            cnt   <= '0;
            acc   <= '0;
            ovf   <= 1'b0;
            busy  <= 1'b1;
            if (len == '0) begin
              state     <= DONE;
              res_valid <= 1'b1;
            end else begin
              state      <= ACC;
              prod_ready <= 1'b1;
            end
          end
        end
        ACC: begin
          if (prod_valid) begin
            acc <= acc_next;
            ovf <= ovf | add_ovf;
            cnt <= cnt_inc;
            if (cnt_inc == len_q) begin
              state      <= DONE;
              prod_ready <= 1'b0;
              res_valid  <= 1'b1;
            end
          end
        end
        DONE: begin
          // acc and ovf stay put so the result survives the transfer.
          if (res_ready) begin
            state     <= IDLE;
            res_valid <= 1'b0;
            busy      <= 1'b0;
          end
        end
        default: begin
          state      <= IDLE;
          prod_ready <= 1'b0;
          res_valid  <= 1'b0;
          busy       <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_booth_product_accumulator.sv
// Directed bench for booth_product_accumulator: a 16-bit instance for the main flows
// and an 8-bit instance for overflow (expectations follow BOOTH_ACC_SAT_EN).
module tb_booth_product_accumulator;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // 16-bit instance
  logic               start, prod_valid, res_ready;
  logic [3:0]         len;
  logic signed [7:0]  prod_data;
  logic               prod_ready, res_valid, ovf, busy;
  logic signed [15:0] res_data;

  // 8-bit instance
  logic               start8, prod_valid8, res_ready8;
  logic [3:0]         len8;
  logic signed [7:0]  prod_data8;
  logic               prod_ready8, res_valid8, ovf8, busy8;
  logic signed [7:0]  res_data8;

  int errors = 0;
  int checks = 0;

  booth_product_accumulator #(.ACC_W(16), .CNT_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .len(len),
    .prod_valid(prod_valid), .prod_ready(prod_ready), .prod_data(prod_data),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .ovf(ovf), .busy(busy)
  );

  booth_product_accumulator #(.ACC_W(8), .CNT_W(4)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .len(len8),
    .prod_valid(prod_valid8), .prod_ready(prod_ready8), .prod_data(prod_data8),
    .res_valid(res_valid8), .res_ready(res_ready8), .res_data(res_data8),
    .ovf(ovf8), .busy(busy8)
  );

  task automatic chk(input string tag, input logic signed [31:0] obs,
                     input logic signed [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  initial begin
    start = 0; len = 0; prod_valid = 0; prod_data = 0; res_ready = 0;
    start8 = 0; len8 = 0; prod_valid8 = 0; prod_data8 = 0; res_ready8 = 0;

    // Reset state
    step();
    chk("rst_prod_ready", prod_ready, 0);
    chk("rst_res_valid", res_valid, 0);
    chk("rst_res_data", res_data, 0);
    chk("rst_ovf", ovf, 0);
    chk("rst_busy", busy, 0);
    rst_n = 1;

    // Basic sum: 21 - 56 + 64 = 29
    start = 1; len = 3;
    step();
    chk("basic_busy", busy, 1);
    chk("basic_prod_ready", prod_ready, 1);
    start = 0; prod_valid = 1; prod_data = 21;
    step();
    prod_data = -56;
    step();
    prod_data = 64;
    step();
    prod_valid = 0;
    chk("basic_res_valid", res_valid, 1);
    chk("basic_res_data", res_data, 29);
    chk("basic_ovf", ovf, 0);
    chk("basic_prod_ready_done", prod_ready, 0);
    res_ready = 1;
    step();
    res_ready = 0;
    chk("basic_busy_after", busy, 0);
    chk("basic_res_valid_after", res_valid, 0);
    chk("basic_res_data_hold", res_data, 29);

    // Input stall then output stall: -8, gap, -8 = -16
    start = 1; len = 2;
    step();
    start = 0; prod_valid = 1; prod_data = -8;
    step();
    prod_valid = 0; prod_data = 99;
    step();
    chk("stall_res_valid_gap", res_valid, 0);
    step();
    chk("stall_res_data_gap", res_data, -8);
    prod_valid = 1; prod_data = -8;
    step();
    prod_valid = 0;
    for (int i = 0; i < 5; i++) begin
      chk("ostall_res_valid", res_valid, 1);
      chk("ostall_res_data", res_data, -16);
      step();
    end
    res_ready = 1;
    step();
    res_ready = 0;
    chk("ostall_busy_after", busy, 0);

    // Zero length job
    start = 1; len = 0;
    step();
    start = 0;
    chk("zero_res_valid", res_valid, 1);
    chk("zero_res_data", res_data, 0);
    chk("zero_ovf", ovf, 0);
    chk("zero_prod_ready", prod_ready, 0);
    res_ready = 1;
    step();
    res_ready = 0;
    chk("zero_busy_after", busy, 0);

    // Start ignored while busy: 1 + 2 + 3 = 6
    start = 1; len = 3;
    step();
    start = 0; prod_valid = 1; prod_data = 1;
    step();
    start = 1; len = 1; prod_data = 2;
    step();
    start = 0; prod_data = 3;
    step();
    prod_valid = 0;
    chk("ign_res_data", res_data, 6);
    chk("ign_res_valid", res_valid, 1);
    start = 1; len = 1; res_ready = 1;
    step();
    res_ready = 0;
    chk("ign_start_at_transfer", busy, 0);
    step();
    start = 0;
    chk("ign_start_next_busy", busy, 1);
    chk("ign_start_next_ready", prod_ready, 1);
    prod_valid = 1; prod_data = 5;
    step();
    prod_valid = 0;
    chk("ign_second_res", res_data, 5);
    res_ready = 1;
    step();
    res_ready = 0;

    // Reset mid-job after 2 of 4 beats
    start = 1; len = 4;
    step();
    start = 0; prod_valid = 1; prod_data = 10;
    step();
    prod_data = 20;
    step();
    prod_valid = 0;
    chk("mid_partial", res_data, 30);
    #2 rst_n = 0;
    #1;
    chk("mid_rst_prod_ready", prod_ready, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_res_valid", res_valid, 0);
    chk("mid_rst_res_data", res_data, 0);
    chk("mid_rst_ovf", ovf, 0);
    step();
    rst_n = 1;
    step();
    chk("mid_no_result", res_valid, 0);
    start = 1; len = 1;
    step();
    start = 0; prod_valid = 1; prod_data = 49;
    step();
    prod_valid = 0;
    chk("mid_fresh_res_data", res_data, 49);
    chk("mid_fresh_ovf", ovf, 0);
    res_ready = 1;
    step();
    res_ready = 0;

    // Positive overflow on 8-bit accumulator: 64 + 64
    start8 = 1; len8 = 2;
    step();
    start8 = 0; prod_valid8 = 1; prod_data8 = 64;
    step();
    step();
    prod_valid8 = 0;
    chk("ovfp_res_valid", res_valid8, 1);
`ifdef BOOTH_ACC_SAT_EN
    chk("ovfp_res_data", res_data8, 127);
`else
    chk("ovfp_res_data", res_data8, -128);
`endif
    chk("ovfp_ovf", ovf8, 1);
    res_ready8 = 1;
    step();
    res_ready8 = 0;

    // Negative overflow: -64 - 64 - 1
    start8 = 1; len8 = 3;
    step();
    chk("ovfn_ovf_cleared", ovf8, 0);
    start8 = 0; prod_valid8 = 1; prod_data8 = -64;
    step();
    step();
    chk("ovfn_no_ovf_yet", ovf8, 0);
    chk("ovfn_partial", res_data8, -128);
    prod_data8 = -1;
    step();
    prod_valid8 = 0;
`ifdef BOOTH_ACC_SAT_EN
    chk("ovfn_res_data", res_data8, -128);
`else
    chk("ovfn_res_data", res_data8, 127);
`endif
    chk("ovfn_ovf", ovf8, 1);
    res_ready8 = 1;
    step();
    res_ready8 = 0;
    chk("ovfn_ovf_hold", ovf8, 1);
    chk("ovfn_busy_after", busy8, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/booth_product_accumulator.md
# booth_product_accumulator

- Downstream consumer of the 4-bit signed Booth multiplier.
- Accepts a stream of signed 8-bit products over a valid/ready handshake and sums a programmed number of them into a wider signed accumulator.
- Presents the sum on a valid/ready result port.
- Forms the back end of a dot-product / MAC datapath built around the combinational multiplier.

## Interface

Parameters:
- ACC_W, default 16: accumulator and result width in bits; legal range 8 to 32.
- CNT_W, default 4: width of the job-length field; a job holds at most 2^CNT_W-1 products.

Ports:
- clk, input, 1: single clock; all state updates on the rising edge.
- rst_n, input, 1: asynchronous, active-low reset.
- start, input, 1: job start request; sampled only in IDLE.
- len, input, CNT_W: number of products in the job; sampled with start.
- prod_valid, input, 1: prod_data is valid.
- prod_ready, output, 1: block accepts a product this cycle.
- prod_data, input, 8: signed product from the multiplier.
- res_valid, output, 1: res_data holds a finished sum.
- res_ready, input, 1: downstream accepts the result.
- res_data, output, ACC_W: signed accumulated sum.
- ovf, output, 1: sticky per-job flag; set when any addition in the current job overflowed signed ACC_W.
- busy, output, 1: high in any state other than IDLE.

## Operation

State machine with three states:
- IDLE:
  - prod_ready=0, res_valid=0.
  - start=1 latches len, clears acc, the beat counter and ovf.
  - Goes to ACC, or to DONE with acc=0 if len==0.
- ACC:
  - prod_ready=1.
  - Each beat with prod_valid&prod_ready adds sign_extend(prod_data, ACC_W) to acc and increments the counter.
  - The beat that makes the count equal len goes to DONE.
- DONE:
  - res_valid=1, res_data=acc, ovf stable.
  - res_valid&res_ready returns the block to IDLE.
  - res_data and ovf hold their values after the transfer until the next start.

Arithmetic and handshake rules:
- Overflow is detected when both addends have the same sign and the sum's sign differs; detection sets ovf.
- Default behaviour is two's-complement wrap-around (see Configuration).
- start outside IDLE is ignored; there is no queueing and no error flag.
- prod_valid while prod_ready=0 is ignored; the upstream must hold the data.
- res_data and ovf do not change while res_valid=1 and res_ready=0.

## Timing

- Reset values: prod_ready=0, res_valid=0, res_data=0, ovf=0, busy=0, state=IDLE, acc=0, counter=0.
- start at edge N: busy=1 and prod_ready=1 from cycle N+1. For len==0, res_valid=1 from cycle N+1 instead.
- Throughput is one product per cycle with no bubbles when prod_valid stays high.
- Last accepted beat at edge M: res_valid=1 from cycle M+1, with res_data including that beat.
- A result transfer at edge K: IDLE from cycle K+1. A start asserted in the same cycle K is ignored. The earliest accepted start is in cycle K+1.
- Reset asserted mid-job: all outputs go to their reset values immediately (asynchronous). The partial sum is discarded. No result is produced after release.
- Reset is released synchronously to clk; the first start is accepted on the first edge after release.

## Configuration

- BOOTH_ACC_SAT_EN defined:
  - On overflow, acc saturates to 2^(ACC_W-1)-1 for positive overflow or -2^(ACC_W-1) for negative overflow.
  - ovf is set.
  - Later beats continue from the saturated value.
- BOOTH_ACC_SAT_EN not defined:
  - acc wraps modulo 2^ACC_W.
  - ovf is still set.
- Port list and timing are identical in both builds.

## Test plan

- Basic sum: ACC_W=16, len=3, products 21, -56, 64 back-to-back → res_valid one cycle after the third beat, res_data=29, ovf=0; with res_ready=1, busy=0 on the following cycle.
- Backpressure on both ports:
  - Input stall: len=2, products -8 then -8 with prod_valid deasserted two cycles between them → exactly two beats accepted, res_data=-16.
  - Output stall: hold res_ready=0 for 5 cycles → res_valid and res_data stable throughout.
- Overflow, ACC_W=8, len=2, products 64 then 64:
  - Without BOOTH_ACC_SAT_EN → res_data=-128 (0x80), ovf=1.
  - With BOOTH_ACC_SAT_EN → res_data=127, ovf=1.
  - Negative case, products -64, -64, -1: wrap build gives 127, sat build gives -128; both give ovf=1.
- Zero length: start with len=0 → res_valid=1 on the next cycle, res_data=0, ovf=0, prod_ready never asserted.
- Start ignored while busy: pulse start with len=1 during ACC of a len=3 job with products 1, 2, 3 → single result res_data=6; next start is accepted only after the result transfer.
- Reset mid-job: assert rst_n=0 after 2 of 4 beats → all outputs 0 immediately. After release, a fresh len=1 job with product 49 gives res_data=49, ovf=0.
